serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits, minuend; sampled on the accepting edge only.
REQ-006 The block SHALL have port b, input, WIDTH bits, subtrahend; sampled on the accepting edge only.
REQ-007 The block SHALL have port busy, output, 1 bit, high while bits are being processed (RUN).
REQ-008 The block SHALL have port done, output, 1 bit, single-cycle pulse marking result valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits, registered result a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit, final borrow: 1 when a < b as unsigned values.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture a and b into shift registers, clear the internal borrow, clear the bit counter, and enter RUN (the "accept edge").
REQ-013 In IDLE with start=0, the state SHALL remain IDLE and all outputs SHALL hold.
REQ-014 In RUN, each rising edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ bor; bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor).
REQ-015 Each processed d SHALL be shifted into the result register from the MSB end, so after WIDTH bits result bit i equals d of step i.
REQ-016 The bit counter SHALL count 0..WIDTH-1; on the edge processing bit WIDTH-1, the FSM SHALL enter DONE and load diff and borrow_out from the completed result and the final borrow.
REQ-017 busy SHALL be 1 exactly in RUN: for WIDTH cycles, starting the cycle after the accept edge.
REQ-018 done SHALL be 1 exactly in DONE: one cycle, WIDTH+1 cycles after the accept edge; the FSM SHALL return to IDLE on the next edge.
REQ-019 start asserted in RUN or DONE SHALL be ignored, with no queuing; a new operation is accepted only from IDLE.
REQ-020 Changes on a and b after the accept edge SHALL NOT affect the operation in progress.
REQ-021 diff and borrow_out SHALL change only on entry to DONE and SHALL hold their values until the next completion or reset.
REQ-022 Minimum accept-to-accept spacing SHALL be WIDTH+2 cycles (start held high continuously yields this rate).

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force state to IDLE and busy=0, done=0, diff=0, borrow_out=0, and clear the internal shift registers, counter and borrow.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-026 The bench SHALL check a=0x5A, b=0x23, start pulse -> busy high for 8 cycles, then done pulse with diff=0x37, borrow_out=0.
REQ-027 The bench SHALL check a=0x10, b=0x20 -> diff=0xF0, borrow_out=1; and a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-028 The bench SHALL check a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; and a=0x80, b=0x00 -> diff=0x80, borrow_out=0.
REQ-029 The bench SHALL check that start re-pulsed in RUN with changed a and b -> result reflects the original operands; exactly one done pulse.
REQ-030 The bench SHALL check rst_n pulsed low in the 4th RUN cycle -> outputs 0 immediately; no done; a following operation 0x09-0x03 yields diff=0x06.
REQ-031 The bench SHALL check start held high continuously -> accepts exactly every 10 cycles with correct results each time, and SHALL compare every result against a - b mod 256 over an exhaustive or random sweep.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor. Computes a - b modulo 2^WIDTH
//             one bit per clock, LSB first, with a final borrow flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      clock, all state updates on the rising edge
//    rst_n      in   1      asynchronous active-low reset
//    start      in   1      request a subtraction (sampled only in IDLE)
//    a          in   WIDTH  minuend, captured on the accept edge
//    b          in   WIDTH  subtrahend, captured on the accept edge
//    busy       out  1      high while bits are being processed
//    done       out  1      one-cycle pulse, diff/borrow_out just updated
//    diff       out  WIDTH  registered result a - b mod 2^WIDTH
//    borrow_out out  1      final borrow, 1 when a < b (unsigned)
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter only needs to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] a_sh_q,       a_sh_d;
    logic [WIDTH-1:0] b_sh_q,       b_sh_d;
    logic [WIDTH-1:0] res_q,        res_d;
    logic             bor_q,        bor_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] diff_q,       diff_d;
    logic             borrow_out_q, borrow_out_d;

    // One-bit full-subtractor cell on the current LSBs.
    logic             d_bit;
    logic             bor_nxt;
    logic [WIDTH-1:0] res_shifted;

    always_comb begin
        d_bit       = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
        bor_nxt     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
        // New bit enters at the MSB so that after WIDTH steps bit i holds step i.
        res_shifted = {d_bit, res_q[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        bor_d        = bor_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = res_shifted;
                bor_d  = bor_nxt;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish the completed word and final borrow.
                    diff_d       = res_shifted;
                    borrow_out_d = bor_nxt;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end

            DONE: begin
                // start is deliberately not looked at here: no queuing.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            bor_q        <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            bor_q        <= bor_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    // Status decodes straight from the state register so reset clears them
    // without waiting for a clock.
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8).
//             A cycle-level reference model predicts accepts, busy/done
//             timing and results; a monitor compares every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: borrow is the sign bit of the widened difference.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: phase 0 = idle, 1..W = processing, W+1 = result.
    // Expected results are queued at the predicted accept edge.
    // ------------------------------------------------------------------
    int          m_phase = 0;
    logic [W:0]  exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            exp_q.delete();
        end else if (m_phase == 0) begin
            if (start === 1'b1) begin
                exp_q.push_back(ref_sub(a, b));
                m_phase = 1;
            end
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: timing every cycle, result on every done, hold otherwise.
    // ------------------------------------------------------------------
    logic [W:0] hold = '0;

    always @(negedge clk) begin
        if (!rst_n) hold = '0;
        check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
        check("done", 32'(done), 32'(m_phase == W + 1));
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                hold = exp_q.pop_front();
                check("diff", 32'(diff), 32'(hold[W-1:0]));
                check("borrow_out", 32'(borrow_out), 32'(hold[W]));
            end
        end else begin
            check("diff_hold", 32'(diff), 32'(hold[W-1:0]));
            check("borrow_hold", 32'(borrow_out), 32'(hold[W]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_done();
        bit found = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("done_timeout", 32'(found), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] ed, input logic eb);
        @(negedge clk);
        start = 1'b1; a = xa; b = xb;
        @(negedge clk);
        // Scramble operands right after acceptance; result must not care.
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        wait_done();
        check("op_diff", 32'(diff), 32'(ed));
        check("op_borrow", 32'(borrow_out), 32'(eb));
        @(negedge clk);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed corner cases
        do_op(8'h5A, 8'h23, 8'h37, 1'b0);
        do_op(8'h10, 8'h20, 8'hF0, 1'b1);
        do_op(8'h00, 8'h01, 8'hFF, 1'b1);
        do_op(8'hFF, 8'hFF, 8'h00, 1'b0);
        do_op(8'h80, 8'h00, 8'h80, 1'b0);

        // start re-pulsed during RUN with different operands is ignored
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; a = 8'h77; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'hFF;
        wait_done();
        check("repulse_diff", 32'(diff), 32'h66);
        check("repulse_borrow", 32'(borrow_out), 32'd0);
        repeat (W + 4) @(negedge clk);
        check("repulse_done_count", 32'(done_seen - d0), 32'd1);

        // Asynchronous reset in the 4th RUN cycle
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; a = 8'h44; b = 8'h11;
        @(negedge clk);              // RUN cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk);   // RUN cycle 4
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_diff", 32'(diff), 32'd0);
        check("arst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("arst_no_done", 32'(done_seen - d0), 32'd0);
        do_op(8'h09, 8'h03, 8'h06, 1'b0);

        // start held high: one accept every W+2 cycles
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 6 * (W + 2); i++) begin
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("continuous_done_count", 32'(done_seen - d0), 32'd6);

        // Random sweep with random gaps (some starts land mid-operation)
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            start = 1'b0; a = W'($urandom); b = W'($urandom);
            repeat ($urandom_range(0, W + 3)) @(negedge clk);
        end

        // Drain outstanding results, bounded
        for (int i = 0; i < 4 * W && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
